// File: rtl/ex_operand_stage_pkg.sv
// Shared encodings for the EX operand stage: ALU control codes, funct codes,
// alu_op encodings, id_ctl bit positions and forwarding selects.
package ex_operand_stage_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } alu_op_e;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_MUL = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_MUL = 6'h18;

    // id_ctl = {alusrc, regwrite, memread, memwrite, memtoreg}
    localparam int CTL_ALUSRC   = 4;
    localparam int CTL_REGWRITE = 3;
    localparam int CTL_MEMREAD  = 2;
    localparam int CTL_MEMWRITE = 1;
    localparam int CTL_MEMTOREG = 0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_EXM = 2'd2
    } fwd_sel_e;

    function automatic logic [3:0] alu_ctrl_decode(input logic [1:0] op, input logic [5:0] funct);
        logic [3:0] c;
        c = ALU_NOP;
        case (op)
            ALUOP_ADD:   c = ALU_ADD;
            ALUOP_SUB:   c = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD:  c = ALU_ADD;
                    FN_SUB:  c = ALU_SUB;
                    FN_AND:  c = ALU_AND;
                    FN_OR:   c = ALU_OR;
                    FN_SLT:  c = ALU_SLT;
                    FN_NOR:  c = ALU_NOR;
                    FN_MUL:  c = ALU_MUL;
                    default: c = ALU_NOP;
                endcase
            end
            default:     c = ALU_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Signal bundle between the ID/forwarding sources and the EX operand stage.
// master = upstream/environment side, slave = the stage itself.
interface ex_operand_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic [REG_AW-1:0] id_rd_i;
    logic [DATA_W-1:0] id_rs_data_i;
    logic [DATA_W-1:0] id_rt_data_i;
    logic [DATA_W-1:0] id_imm_i;
    logic [1:0]        id_alu_op_i;
    logic [5:0]        id_funct_i;
    logic [4:0]        id_ctl_i;
    logic              flush_i;
    logic              exm_regwrite_i;
    logic [REG_AW-1:0] exm_rd_i;
    logic [DATA_W-1:0] exm_data_i;
    logic              wb_regwrite_i;
    logic [REG_AW-1:0] wb_rd_i;
    logic [DATA_W-1:0] wb_data_i;
    logic              hazard_o;
    logic [DATA_W-1:0] src1_o;
    logic [DATA_W-1:0] src2_o;
    logic [3:0]        ctrl_o;
    logic [DATA_W-1:0] store_data_o;
    logic [REG_AW-1:0] ex_rd_o;
    logic [3:0]        ex_ctl_o;
    logic              ex_valid_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_rs_data_i, id_rt_data_i, id_imm_i,
               id_alu_op_i, id_funct_i, id_ctl_i, flush_i,
               exm_regwrite_i, exm_rd_i, exm_data_i, wb_regwrite_i, wb_rd_i, wb_data_i,
        input  hazard_o, src1_o, src2_o, ctrl_o, store_data_o, ex_rd_o, ex_ctl_o, ex_valid_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_rs_data_i, id_rt_data_i, id_imm_i,
               id_alu_op_i, id_funct_i, id_ctl_i, flush_i,
               exm_regwrite_i, exm_rd_i, exm_data_i, wb_regwrite_i, wb_rd_i, wb_data_i,
        output hazard_o, src1_o, src2_o, ctrl_o, store_data_o, ex_rd_o, ex_ctl_o, ex_valid_o
    );
endinterface

// File: rtl/ex_operand_stage_fwd_unit.sv
// Combinational forwarding select for the two EX sources; the EX/MEM stage
// holds the younger result so it wins over MEM/WB, and r0 is never forwarded.
module fwd_unit
    import ex_operand_stage_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              exm_regwrite_i,
    input  logic [REG_AW-1:0] exm_rd_i,
    input  logic              wb_regwrite_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    output fwd_sel_e          fwd_rs_o,
    output fwd_sel_e          fwd_rt_o
);
    logic exm_hit_rs, exm_hit_rt, wb_hit_rs, wb_hit_rt;

    assign exm_hit_rs = exm_regwrite_i && (exm_rd_i != '0) && (exm_rd_i == rs_i);
    assign exm_hit_rt = exm_regwrite_i && (exm_rd_i != '0) && (exm_rd_i == rt_i);
    assign wb_hit_rs  = wb_regwrite_i  && (wb_rd_i  != '0) && (wb_rd_i  == rs_i);
    assign wb_hit_rt  = wb_regwrite_i  && (wb_rd_i  != '0) && (wb_rd_i  == rt_i);

    assign fwd_rs_o = exm_hit_rs ? FWD_EXM : (wb_hit_rs ? FWD_WB : FWD_RF);
    assign fwd_rt_o = exm_hit_rt ? FWD_EXM : (wb_hit_rt ? FWD_WB : FWD_RF);
endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with load-use hazard detect, registered ALU-ctrl
// decode and zero-latency operand forwarding into the downstream ALU.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_n,
    ex_operand_stage_if.slave bus
);
    logic              valid_q, valid_d;
    logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [4:0]        ctl_q, ctl_d;
    logic [3:0]        ctrl_q, ctrl_d;

    logic              hazard, bubble;
    fwd_sel_e          fwd_rs, fwd_rt;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;

    // Only the load's rt matters: that is the register it is about to write.
    assign hazard = valid_q && ctl_q[CTL_MEMREAD] && (rt_q != '0) && bus.id_valid_i &&
                    ((rt_q == bus.id_rs_i) || (rt_q == bus.id_rt_i));
    assign bubble = bus.flush_i || hazard;

    always_comb begin
        valid_d   = 1'b0;
        rs_d      = '0;
        rt_d      = '0;
        rd_d      = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        ctl_d     = '0;
        ctrl_d    = ALU_AND;
        if (!bubble) begin
            valid_d   = bus.id_valid_i;
            rs_d      = bus.id_rs_i;
            rt_d      = bus.id_rt_i;
            rd_d      = bus.id_rd_i;
            rs_data_d = bus.id_rs_data_i;
            rt_data_d = bus.id_rt_data_i;
            imm_d     = bus.id_imm_i;
            ctl_d     = bus.id_ctl_i;
            ctrl_d    = alu_ctrl_decode(bus.id_alu_op_i, bus.id_funct_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            ctl_q     <= '0;
            ctrl_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            ctl_q     <= ctl_d;
            ctrl_q    <= ctrl_d;
        end
    end

    fwd_unit #(.REG_AW(REG_AW)) u_fwd (
        .exm_regwrite_i (bus.exm_regwrite_i),
        .exm_rd_i       (bus.exm_rd_i),
        .wb_regwrite_i  (bus.wb_regwrite_i),
        .wb_rd_i        (bus.wb_rd_i),
        .rs_i           (rs_q),
        .rt_i           (rt_q),
        .fwd_rs_o       (fwd_rs),
        .fwd_rt_o       (fwd_rt)
    );

    always_comb begin
        case (fwd_rs)
            FWD_EXM: rs_fwd = bus.exm_data_i;
            FWD_WB:  rs_fwd = bus.wb_data_i;
            default: rs_fwd = rs_data_q;
        endcase
        case (fwd_rt)
            FWD_EXM: rt_fwd = bus.exm_data_i;
            FWD_WB:  rt_fwd = bus.wb_data_i;
            default: rt_fwd = rt_data_q;
        endcase
    end

    assign bus.hazard_o     = hazard;
    assign bus.src1_o       = rs_fwd;
    assign bus.src2_o       = ctl_q[CTL_ALUSRC] ? imm_q : rt_fwd;
    assign bus.store_data_o = rt_fwd;
    assign bus.ctrl_o       = ctrl_q;
    assign bus.ex_rd_o      = rd_q;
    assign bus.ex_ctl_o     = valid_q ? ctl_q[3:0] : 4'b0000;
    assign bus.ex_valid_o   = valid_q;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboarded bench: stimulus pushes the model's expectation per cycle, a
// negedge monitor pops and compares; directed spot checks cover the key cases.
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_i = ~clk_i;

    ex_operand_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();
    ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (.clk_i(clk_i), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic valid; logic [4:0] rs, rt, rd; logic [31:0] rs_data, rt_data, imm;
        logic [1:0] op; logic [5:0] funct; logic [4:0] ctl; logic flush;
        logic exm_we; logic [4:0] exm_rd; logic [31:0] exm_data;
        logic wb_we; logic [4:0] wb_rd; logic [31:0] wb_data;
    } stim_t;

    // What the EX slot holds; known=0 means a bubble whose data fields are don't-care.
    typedef struct {
        logic known, valid; logic [4:0] rs, rt, rd; logic [31:0] rs_data, rt_data, imm;
        logic [4:0] ctl; logic [3:0] ctrl;
    } slot_t;

    typedef struct {
        logic known, hazard, valid; logic [31:0] src1, src2, store;
        logic [3:0] ctrl, ex_ctl; logic [4:0] rd;
    } exp_t;

    exp_t  q[$];
    exp_t  me;
    slot_t m, m_nxt;
    stim_t idle;
    int    n_cmp = 0;
    int    n_bad = 0;
    logic [5:0] fn_list [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h18, 6'h3F};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_alu(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b1111;
        case (fn)
            6'h20: return 4'b0010;
            6'h22: return 4'b0110;
            6'h24: return 4'b0000;
            6'h25: return 4'b0001;
            6'h2A: return 4'b0111;
            6'h27: return 4'b1100;
            6'h18: return 4'b0100;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] rf, input stim_t s);
        if (s.exm_we && r != 0 && s.exm_rd == r) return s.exm_data;
        if (s.wb_we && r != 0 && s.wb_rd == r) return s.wb_data;
        return rf;
    endfunction

    function automatic logic m_hazard(input slot_t x, input stim_t s);
        return x.valid && x.ctl[2] && x.rt != 0 && s.valid && (x.rt == s.rs || x.rt == s.rt);
    endfunction

    function automatic slot_t m_next(input stim_t s, input logic hz);
        slot_t n;
        n = '{known: 1'b0, valid: 1'b0, rs: '0, rt: '0, rd: '0, rs_data: '0, rt_data: '0,
              imm: '0, ctl: '0, ctrl: '0};
        if (!(s.flush || hz)) begin
            n = '{known: 1'b1, valid: s.valid, rs: s.rs, rt: s.rt, rd: s.rd, rs_data: s.rs_data,
                  rt_data: s.rt_data, imm: s.imm, ctl: s.ctl, ctrl: m_alu(s.op, s.funct)};
        end
        return n;
    endfunction

    task automatic drive(input stim_t s);
        bus.id_valid_i = s.valid;     bus.id_rs_i = s.rs;           bus.id_rt_i = s.rt;
        bus.id_rd_i = s.rd;           bus.id_rs_data_i = s.rs_data; bus.id_rt_data_i = s.rt_data;
        bus.id_imm_i = s.imm;         bus.id_alu_op_i = s.op;       bus.id_funct_i = s.funct;
        bus.id_ctl_i = s.ctl;         bus.flush_i = s.flush;
        bus.exm_regwrite_i = s.exm_we; bus.exm_rd_i = s.exm_rd;     bus.exm_data_i = s.exm_data;
        bus.wb_regwrite_i = s.wb_we;   bus.wb_rd_i = s.wb_rd;       bus.wb_data_i = s.wb_data;
    endtask

    task automatic cyc(input stim_t s);
        exp_t e;
        @(posedge clk_i); #1;
        m = m_nxt;
        drive(s);
        e.known  = m.known;
        e.hazard = m_hazard(m, s);
        e.valid  = m.valid;
        e.ctrl   = m.ctrl;
        e.ex_ctl = m.valid ? m.ctl[3:0] : 4'b0000;
        e.rd     = m.rd;
        e.src1   = m_fwd(m.rs, m.rs_data, s);
        e.store  = m_fwd(m.rt, m.rt_data, s);
        e.src2   = m.ctl[4] ? m.imm : e.store;
        q.push_back(e);
        m_nxt = m_next(s, e.hazard);
    endtask

    task automatic do_reset();
        @(posedge clk_i); #2;
        rst_n = 1'b0;
        drive(idle);
        #1;
        chk("rst_hazard", {31'd0, bus.hazard_o}, 32'd0);
        chk("rst_src1", bus.src1_o, 32'd0);
        chk("rst_src2", bus.src2_o, 32'd0);
        chk("rst_store", bus.store_data_o, 32'd0);
        chk("rst_ctrl", {28'd0, bus.ctrl_o}, 32'd0);
        chk("rst_ex_rd", {27'd0, bus.ex_rd_o}, 32'd0);
        chk("rst_ex_ctl", {28'd0, bus.ex_ctl_o}, 32'd0);
        chk("rst_valid", {31'd0, bus.ex_valid_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #2;
        rst_n = 1'b1;
        m = '{known: 1'b1, valid: 1'b0, rs: '0, rt: '0, rd: '0, rs_data: '0, rt_data: '0,
              imm: '0, ctl: '0, ctrl: 4'b0000};
        m_nxt = m_next(idle, m_hazard(m, idle));
    endtask

    function automatic stim_t rnd();
        stim_t s;
        s.valid = ($urandom_range(0, 7) != 0);
        s.rs = 5'($urandom_range(0, 7));  s.rt = 5'($urandom_range(0, 7));
        s.rd = 5'($urandom_range(0, 7));
        s.rs_data = $urandom; s.rt_data = $urandom; s.imm = $urandom;
        s.op = 2'($urandom_range(0, 3));
        s.funct = fn_list[$urandom_range(0, 7)];
        s.ctl = 5'($urandom);
        s.flush = ($urandom_range(0, 7) == 0);
        s.exm_we = 1'($urandom); s.exm_rd = 5'($urandom_range(0, 7)); s.exm_data = $urandom;
        s.wb_we = 1'($urandom);  s.wb_rd = 5'($urandom_range(0, 7));  s.wb_data = $urandom;
        return s;
    endfunction

    always @(negedge clk_i) begin
        if (rst_n && q.size() > 0) begin
            me = q.pop_front();
            chk("hazard", {31'd0, bus.hazard_o}, {31'd0, me.hazard});
            chk("ex_valid", {31'd0, bus.ex_valid_o}, {31'd0, me.valid});
            chk("ex_ctl", {28'd0, bus.ex_ctl_o}, {28'd0, me.ex_ctl});
            chk("ctrl", {28'd0, bus.ctrl_o}, {28'd0, me.ctrl});
            if (me.known) begin
                chk("src1", bus.src1_o, me.src1);
                chk("src2", bus.src2_o, me.src2);
                chk("store", bus.store_data_o, me.store);
                chk("ex_rd", {27'd0, bus.ex_rd_o}, {27'd0, me.rd});
            end
        end
    end

    initial begin
        stim_t s, ld, use_i;
        idle = '{valid: 1'b0, rs: '0, rt: '0, rd: '0, rs_data: '0, rt_data: '0, imm: '0,
                 op: 2'b00, funct: '0, ctl: '0, flush: 1'b0, exm_we: 1'b0, exm_rd: '0,
                 exm_data: '0, wb_we: 1'b0, wb_rd: '0, wb_data: '0};
        drive(idle);
        do_reset();

        // R-type add
        s = idle; s.valid = 1; s.rs = 1; s.rt = 2; s.rd = 3; s.rs_data = 5; s.rt_data = 7;
        s.op = 2'b10; s.funct = 6'h20; s.ctl = 5'b01000;
        cyc(s); cyc(idle); #1;
        chk("add_src1", bus.src1_o, 32'd5);
        chk("add_src2", bus.src2_o, 32'd7);
        chk("add_ctrl", {28'd0, bus.ctrl_o}, 32'h2);
        chk("add_valid", {31'd0, bus.ex_valid_o}, 32'd1);

        // forwarding priority on rs=3
        s = idle; s.valid = 1; s.rs = 3; s.rt = 1; s.rs_data = 32'h11; s.op = 2'b10; s.funct = 6'h20;
        cyc(s);
        s.exm_we = 1; s.exm_rd = 3; s.exm_data = 32'hAA; s.wb_we = 1; s.wb_rd = 3; s.wb_data = 32'hBB;
        cyc(s); #1;
        chk("fwd_exm", bus.src1_o, 32'hAA);
        s.valid = 0; s.exm_we = 0;
        cyc(s); #1;
        chk("fwd_wb", bus.src1_o, 32'hBB);

        // r0 never forwarded
        s = idle; s.valid = 1; s.rs = 0; s.rs_data = 32'h12;
        cyc(s);
        s = idle; s.exm_we = 1; s.exm_rd = 0; s.exm_data = 32'hFF;
        cyc(s); #1;
        chk("r0_nofwd", bus.src1_o, 32'h12);

        // load-use stall
        ld = idle; ld.valid = 1; ld.rs = 1; ld.rt = 4; ld.rd = 4; ld.ctl = 5'b11101;
        use_i = idle; use_i.valid = 1; use_i.rs = 4; use_i.rt = 5; use_i.rd = 6;
        use_i.op = 2'b10; use_i.funct = 6'h22; use_i.ctl = 5'b01000;
        cyc(ld); cyc(use_i); #1;
        chk("lu_hazard", {31'd0, bus.hazard_o}, 32'd1);
        cyc(use_i); #1;
        chk("lu_bub_valid", {31'd0, bus.ex_valid_o}, 32'd0);
        chk("lu_bub_ctl", {28'd0, bus.ex_ctl_o}, 32'd0);
        chk("lu_bub_ctrl", {28'd0, bus.ctrl_o}, 32'd0);
        cyc(idle); #1;
        chk("lu_held_valid", {31'd0, bus.ex_valid_o}, 32'd1);
        chk("lu_held_ctrl", {28'd0, bus.ctrl_o}, 32'h6);

        // flush a store
        s = idle; s.valid = 1; s.rs = 2; s.rt = 3; s.ctl = 5'b10010; s.flush = 1;
        cyc(s); cyc(idle); #1;
        chk("fl_valid", {31'd0, bus.ex_valid_o}, 32'd0);
        chk("fl_memwrite", {31'd0, bus.ex_ctl_o[1]}, 32'd0);

        // flush and hazard together: one bubble only
        cyc(ld);
        s = use_i; s.flush = 1;
        cyc(s); #1;
        chk("flhz_hazard", {31'd0, bus.hazard_o}, 32'd1);
        cyc(use_i); #1;
        chk("flhz_bubble", {31'd0, bus.ex_valid_o}, 32'd0);
        cyc(idle); #1;
        chk("flhz_capture", {31'd0, bus.ex_valid_o}, 32'd1);

        for (int i = 0; i < 200; i++) cyc(rnd());

        do_reset();
        s = idle; s.valid = 1; s.op = 2'b10; s.funct = 6'h3F;
        cyc(s); cyc(idle); #1;
        chk("bad_funct", {28'd0, bus.ctrl_o}, 32'hF);

        for (int i = 0; i < 200; i++) cyc(rnd());
        cyc(idle);
        @(posedge clk_i); #6;
        chk("queue_drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
